// File: rtl/split_check_sched.sv
// split_check_sched: round-robin scheduler that shares one combinational split checker among
// NREQ requesters. It returns held SAT/UNSAT verdicts and keeps saturating verdict counters.
module split_check_sched #(
    parameter int NREQ    = 4,
    parameter int VEC_W   = 64,
    parameter int CHK_LAT = 0,
    parameter int CNT_W   = 16,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*VEC_W-1:0] req_vec_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [VEC_W-1:0]      chk_vec_o,
    output logic                  chk_start_o,
    input  logic                  chk_x_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDW-1:0]        rsp_id_o,
    output logic                  rsp_sat_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      sat_cnt_o,
    output logic [CNT_W-1:0]      unsat_cnt_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t           state_q;
    logic [IDW-1:0]   ptr_q, ptr_d, gnt_idx, rsp_id_q;
    logic             gnt_vld, chk_start_q, rsp_valid_q, rsp_sat_q, busy_q;
    logic [3:0]       lat_q;
    logic [VEC_W-1:0] chk_vec_q, vec_d;
    logic [CNT_W-1:0] sat_cnt_q, unsat_cnt_q;
    // Scan downward so the last hit is the first valid index at or after the pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[(int'(ptr_q) + k) % NREQ]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end
    assign ptr_d       = IDW'((int'(gnt_idx) + 1) % NREQ);
    assign vec_d       = req_vec_i[int'(gnt_idx)*VEC_W +: VEC_W];
    assign req_ready_o = (state_q == IDLE && gnt_vld && !rst) ? NREQ'(1) << gnt_idx : '0;
    assign chk_vec_o   = chk_vec_q;
    assign chk_start_o = chk_start_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_sat_o   = rsp_sat_q;
    assign busy_o      = busy_q;
    assign sat_cnt_o   = sat_cnt_q;
    assign unsat_cnt_o = unsat_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lat_q       <= '0;
            chk_vec_q   <= '0;
            chk_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
            sat_cnt_q   <= '0;
            unsat_cnt_q <= '0;
        end else begin
            chk_start_q <= 1'b0;
            case (state_q)
                IDLE: if (gnt_vld) begin
                    chk_vec_q   <= vec_d;
                    rsp_id_q    <= gnt_idx;
                    ptr_q       <= ptr_d;
                    lat_q       <= 4'(CHK_LAT);
                    chk_start_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= WAIT;
                end
                WAIT: if (lat_q == '0) begin
                    rsp_sat_q   <= chk_x_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end else begin
                    lat_q <= lat_q - 4'd1;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                    if (rsp_sat_q) sat_cnt_q <= sat_cnt_q + CNT_W'(~&sat_cnt_q);
                    else unsat_cnt_q <= unsat_cnt_q + CNT_W'(~&unsat_cnt_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
